// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache front-end controller.
package cache_pkg;

    localparam int NREQ_DEF = 2;
    localparam int AW_DEF   = 8;
    localparam int LW_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FILL,
        INSTALL,
        WRITE,
        RESP
    } state_e;

endpackage

// File: rtl/cache_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the rotating pointer, advances it past the winner on grant.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] ptr_reg;

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_reg) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (en && valid) begin
            ptr_reg <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Cache front-end: arbitrates requesters, sequences lookup / miss fill / write-through,
// and pulses done to the granted requester. One transaction in flight.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int ADDR_WIDTH = AW_DEF,
    parameter int LINE_WIDTH = LW_DEF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*LINE_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            done,
    output logic [LINE_WIDTH-1:0]      rdata,
    output logic [ADDR_WIDTH-1:0]      c_addr,
    output logic [LINE_WIDTH-1:0]      c_val,
    output logic                       c_read,
    output logic                       c_write,
    input  logic                       c_hit,
    input  logic [LINE_WIDTH-1:0]      c_out,
    output logic                       m_req,
    output logic                       m_we,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [LINE_WIDTH-1:0]      m_wdata,
    input  logic                       m_ack,
    input  logic [LINE_WIDTH-1:0]      m_rdata
);

    localparam int IW = $clog2(NREQ);

    state_e                  state_reg, state_next;
    logic [IW-1:0]           win_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [LINE_WIDTH-1:0]   wdata_reg;
    logic [LINE_WIDTH-1:0]   fill_reg;
    logic [LINE_WIDTH-1:0]   rdata_reg;
    logic                    wr_first_reg;

    logic [NREQ-1:0]         arb_grant;
    logic [IW-1:0]           arb_idx;
    logic                    arb_valid;
    logic                    we_sel;
    logic [ADDR_WIDTH-1:0]   addr_arr  [NREQ];
    logic [LINE_WIDTH-1:0]   wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
            assign done[gi]      = (state_reg == RESP) && (win_reg == IW'(gi));
        end
    endgenerate

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .en      (state_reg == IDLE),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .valid   (arb_valid)
    );

    assign we_sel  = |(req_we & arb_grant);
    assign rdata   = rdata_reg;
    assign c_addr  = addr_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;
    // The cache write port carries fill data on install and request data on write-through.
    assign c_val   = (state_reg == WRITE) ? wdata_reg : fill_reg;

    always_comb begin
        state_next = state_reg;
        c_read     = 1'b0;
        c_write    = 1'b0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        case (state_reg)
            IDLE:    if (arb_valid) state_next = we_sel ? WRITE : LOOKUP;
            LOOKUP: begin
                c_read     = 1'b1;
                state_next = CHECK;
            end
            CHECK:   state_next = c_hit ? RESP : FILL;
            FILL: begin
                m_req = 1'b1;
                if (m_ack) state_next = INSTALL;
            end
            INSTALL: begin
                c_write    = 1'b1;
                state_next = RESP;
            end
            WRITE: begin
                c_write = wr_first_reg;
                m_req   = 1'b1;
                m_we    = 1'b1;
                if (m_ack) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            win_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            fill_reg     <= '0;
            rdata_reg    <= '0;
            wr_first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (arb_valid) begin
                    win_reg      <= arb_idx;
                    addr_reg     <= addr_arr[arb_idx];
                    wdata_reg    <= wdata_arr[arb_idx];
                    wr_first_reg <= we_sel;
                end
                CHECK:   if (c_hit) rdata_reg <= c_out;
                FILL:    if (m_ack) fill_reg <= m_rdata;
                INSTALL: rdata_reg <= fill_reg;
                WRITE:   wr_first_reg <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: reset abort, miss/hit reads, write-through, fairness, stray acks.
module tb_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req, req_we, done;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rdata, c_val, c_out, m_wdata, m_rdata;
    logic [7:0]  c_addr, m_addr;
    logic        c_read, c_write, c_hit, m_req, m_we, m_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    cache_ctrl #(.NREQ(2), .ADDR_WIDTH(8), .LINE_WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .c_addr    (c_addr),
        .c_val     (c_val),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_hit     (c_hit),
        .c_out     (c_out),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({done, c_read, c_write, m_req, m_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%b want=000000", {done, c_read, c_write, m_req, m_we});
        end
        n_cmp++;
        if ({rdata, c_addr, c_val, m_addr, m_wdata} !== 112'b0) begin
            n_bad++;
            $display("FAIL reset_data got rdata=%h c_addr=%h c_val=%h m_addr=%h m_wdata=%h want all zero",
                     rdata, c_addr, c_val, m_addr, m_wdata);
        end
        reset_n = 1'b1;
        step();
        req_addr = {8'h00, 8'h34};
        req_we   = 2'b00;
        req      = 2'b01;
        c_hit    = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 8'h34}) begin
            n_bad++;
            $display("FAIL reset_prefill got m_req=%b m_addr=%h want 1/34", m_req, m_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_mreq got=%b want=0", m_req);
        end
        req = 2'b00;
        step();
        reset_n = 1'b1;
        m_ack   = 1'b1;
        m_rdata = 32'hAAAA5555;
        step();
        m_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({done, c_read, c_write, m_req} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_late_ack cyc=%0d got=%b want=00000", i, {done, c_read, c_write, m_req});
            end
            step();
        end
        $display("txn reset-abort: req0 read 34 aborted in FILL, late ack ignored");
    endtask

    task automatic test_read_miss_hit();
        req_addr = {8'h00, 8'h12};
        req_we   = 2'b00;
        req      = 2'b01;
        c_hit    = 1'b0;
        c_out    = 32'h0;
        step();
        n_cmp++;
        if ({c_read, c_write, m_req, c_addr} !== {3'b100, 8'h12}) begin
            n_bad++;
            $display("FAIL miss_lookup got rd/wr/mreq=%b addr=%h want 100/12", {c_read, c_write, m_req}, c_addr);
        end
        step();
        n_cmp++;
        if ({c_read, c_write, m_req, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL miss_check got=%b want=00000", {c_read, c_write, m_req, done});
        end
        step();
        n_cmp++;
        if ({m_req, m_we, m_addr} !== {2'b10, 8'h12}) begin
            n_bad++;
            $display("FAIL miss_fill got m_req=%b m_we=%b m_addr=%h want 1/0/12", m_req, m_we, m_addr);
        end
        req_addr = {8'h00, 8'h55};
        step();
        step();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 8'h12}) begin
            n_bad++;
            $display("FAIL miss_fill_hold got m_req=%b m_addr=%h want 1/12", m_req, m_addr);
        end
        m_ack   = 1'b1;
        m_rdata = 32'hDEADBEEF;
        step();
        m_ack = 1'b0;
        n_cmp++;
        if ({c_write, c_read, m_req, done, c_val} !== {5'b10000, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL miss_install got wr/rd/mreq/done=%b c_val=%h want 10000/deadbeef",
                     {c_write, c_read, m_req, done}, c_val);
        end
        step();
        n_cmp++;
        if ({done, rdata} !== {2'b01, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL miss_resp got done=%b rdata=%h want 01/deadbeef", done, rdata);
        end
        req = 2'b00;
        step();
        n_cmp++;
        if (done !== 2'b00) begin
            n_bad++;
            $display("FAIL miss_done_width got=%b want=00", done);
        end
        $display("txn read-miss: req0 addr 12 rdata %h", rdata);

        req_addr = {8'h00, 8'h12};
        req      = 2'b01;
        c_hit    = 1'b1;
        c_out    = 32'hDEADBEEF;
        for (int cyc = 2; cyc <= 4; cyc++) begin
            step();
            if (cyc < 4) begin
                n_cmp++;
                if ({done, c_write, m_req} !== 4'b0) begin
                    n_bad++;
                    $display("FAIL hit_early cyc=%0d got=%b want=0000", cyc, {done, c_write, m_req});
                end
            end else begin
                n_cmp++;
                if ({done, rdata} !== {2'b01, 32'hDEADBEEF}) begin
                    n_bad++;
                    $display("FAIL hit_resp got done=%b rdata=%h want 01/deadbeef", done, rdata);
                end
            end
        end
        req = 2'b00;
        step();
        $display("txn read-hit: req0 addr 12 rdata %h", rdata);
    endtask

    task automatic test_write();
        req_addr  = {8'h80, 8'h00};
        req_wdata = {32'h0000CAFE, 32'h0};
        req_we    = 2'b10;
        req       = 2'b10;
        step();
        n_cmp++;
        if ({c_write, c_read, m_req, m_we, c_addr, c_val} !== {4'b1011, 8'h80, 32'h0000CAFE}) begin
            n_bad++;
            $display("FAIL wr_first got wr/rd/mreq/mwe=%b c_addr=%h c_val=%h want 1011/80/0000cafe",
                     {c_write, c_read, m_req, m_we}, c_addr, c_val);
        end
        n_cmp++;
        if ({m_addr, m_wdata} !== {8'h80, 32'h0000CAFE}) begin
            n_bad++;
            $display("FAIL wr_mem got m_addr=%h m_wdata=%h want 80/0000cafe", m_addr, m_wdata);
        end
        step();
        n_cmp++;
        if ({c_write, m_req, done} !== 4'b0100) begin
            n_bad++;
            $display("FAIL wr_wait got=%b want=0100", {c_write, m_req, done});
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        n_cmp++;
        if ({done, m_req} !== 3'b100) begin
            n_bad++;
            $display("FAIL wr_resp got done=%b m_req=%b want 10/0", done, m_req);
        end
        req    = 2'b00;
        req_we = 2'b00;
        step();
        n_cmp++;
        if (done !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_done_width got=%b want=00", done);
        end
        $display("txn write: req1 addr 80 wdata 0000cafe");
    endtask

    task automatic test_fairness();
        int got;
        logic [1:0] want;
        got      = 0;
        req_addr = {8'h20, 8'h20};
        req_we   = 2'b00;
        c_hit    = 1'b1;
        c_out    = 32'h11112222;
        req      = 2'b11;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            step();
            if (done !== 2'b00) begin
                want = (got % 2 == 0) ? 2'b01 : 2'b10;
                n_cmp++;
                if ({done, rdata} !== {want, 32'h11112222}) begin
                    n_bad++;
                    $display("FAIL fair_grant%0d got done=%b rdata=%h want %b/11112222", got, done, rdata, want);
                end
                $display("txn fairness: grant %0d done=%b rdata %h", got, done, rdata);
                got++;
            end
        end
        n_cmp++;
        if (got !== 4) begin
            n_bad++;
            $display("FAIL fair_count got=%0d want=4", got);
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_stray_ack();
        m_ack   = 1'b1;
        m_rdata = 32'hBAD0BAD0;
        step();
        m_ack = 1'b0;
        n_cmp++;
        if ({done, c_read, c_write, m_req} !== 5'b0) begin
            n_bad++;
            $display("FAIL stray_idle got=%b want=00000", {done, c_read, c_write, m_req});
        end
        req_addr = {8'h00, 8'h40};
        req_we   = 2'b00;
        req      = 2'b01;
        c_hit    = 1'b0;
        step();
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        n_cmp++;
        if ({m_req, done, c_write} !== 4'b1000) begin
            n_bad++;
            $display("FAIL stray_check got mreq/done/wr=%b want 1000", {m_req, done, c_write});
        end
        req_addr = {8'h00, 8'h99};
        step();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 8'h40}) begin
            n_bad++;
            $display("FAIL stray_addr_latch got m_req=%b m_addr=%h want 1/40", m_req, m_addr);
        end
        m_ack   = 1'b1;
        m_rdata = 32'h12345678;
        step();
        m_ack = 1'b0;
        n_cmp++;
        if ({c_write, c_addr, c_val} !== {1'b1, 8'h40, 32'h12345678}) begin
            n_bad++;
            $display("FAIL stray_install got wr=%b c_addr=%h c_val=%h want 1/40/12345678", c_write, c_addr, c_val);
        end
        step();
        n_cmp++;
        if ({done, rdata} !== {2'b01, 32'h12345678}) begin
            n_bad++;
            $display("FAIL stray_resp got done=%b rdata=%h want 01/12345678", done, rdata);
        end
        req = 2'b00;
        step();
        $display("txn stray-ack: req0 addr 40 rdata %h", rdata);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        c_hit     = 1'b0;
        c_out     = '0;
        m_ack     = 1'b0;
        m_rdata   = '0;
        test_reset();
        test_read_miss_hit();
        test_write();
        test_fairness();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
